// File: rtl/sample_readout_pkg.sv
// Shared definitions for the sample read-back path: state encoding and default widths.
package sample_readout_pkg;

  localparam int DEF_AW = 11;
  localparam int DEF_DW = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;

endpackage

// File: rtl/sample_readout_fifo2.sv
// Two-entry synchronous FIFO buffering RAM read returns; the head is visible
// combinationally and flush empties it in one cycle.
module fifo2
  import sample_readout_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic [1:0]    occ
);

  logic [DW-1:0] slot0_r;
  logic [DW-1:0] slot1_r;
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    occ_r;

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot0_r  <= {DW{1'b0}};
      slot1_r  <= {DW{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else if (flush) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr_r) begin
          slot1_r <= wdata;
        end else begin
          slot0_r <= wdata;
        end
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  // Head-of-queue select.
  always_comb begin
    if (rd_ptr_r) begin
      rdata = slot1_r;
    end else begin
      rdata = slot0_r;
    end
  end

  assign occ = occ_r;

endmodule

// File: rtl/sample_readout.sv
// Read side of the capture ring: issues credit-limited RAM reads over a window
// (ascending or descending, modulo wrap) and streams the words out on valid/ready.
module sample_readout
  import sample_readout_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   count,
  input  logic          reverse,
  input  logic          abort,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  state_t        state_r;
  logic [AW-1:0] addr_r;
  logic [AW:0]   reads_left_r;
  logic [AW:0]   sends_left_r;
  logic          reverse_r;
  logic          inflight_r;
  logic          busy_r;
  logic          done_r;

  logic [1:0]    occ_s;
  logic [DW-1:0] head_s;
  logic          pop_s;
  logic          issue_s;

  // Returned data lands one edge after its read; abort flushes, which also drops that return.
  fifo2 #(.DW(DW)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (abort),
    .push  (inflight_r),
    .pop   (pop_s),
    .wdata (mem_rdata),
    .rdata (head_s),
    .occ   (occ_s)
  );

  // Stream side and read credit: a read may issue only if its return will find a free slot.
  always_comb begin
    tx_valid = (occ_s != 2'd0);
    if (tx_valid) begin
      tx_data = head_s;
    end else begin
      tx_data = {DW{1'b0}};
    end
    pop_s = tx_valid && tx_ready;
    if ((state_r == ST_READ) && (reads_left_r != CNT_ZERO)) begin
      issue_s = (({1'b0, occ_s} + {2'b00, inflight_r}) < (3'd2 + {2'b00, pop_s}));
    end else begin
      issue_s = 1'b0;
    end
  end

  assign mem_en   = issue_s;
  assign mem_addr = addr_r;
  assign busy     = busy_r;
  assign done     = done_r;

  // Window sequencing: address walk, read/send countdown, busy and done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= {AW{1'b0}};
      reads_left_r <= CNT_ZERO;
      sends_left_r <= CNT_ZERO;
      reverse_r    <= 1'b0;
      inflight_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else if (abort) begin
      state_r      <= ST_IDLE;
      reads_left_r <= CNT_ZERO;
      sends_left_r <= CNT_ZERO;
      inflight_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r     <= 1'b0;
      inflight_r <= issue_s;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (count != CNT_ZERO) begin
              state_r      <= ST_READ;
              busy_r       <= 1'b1;
              addr_r       <= start_addr;
              reverse_r    <= reverse;
              reads_left_r <= count;
              sends_left_r <= count;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (issue_s) begin
            addr_r       <= reverse_r ? (addr_r - ADDR_ONE) : (addr_r + ADDR_ONE);
            reads_left_r <= reads_left_r - CNT_ONE;
            if (reads_left_r == CNT_ONE) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          state_r <= ST_DRAIN;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      // The last accepted word closes the window; it can only occur after the last read.
      if (pop_s) begin
        sends_left_r <= sends_left_r - CNT_ONE;
        if (sends_left_r == CNT_ONE) begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_readout.sv
// Directed bench for sample_readout: RAM model returns addr[7:0] one cycle after mem_en.
module tb_sample_readout;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] start_addr;
  logic [11:0] count;
  logic        reverse;
  logic        abort;
  logic        mem_en;
  logic [10:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ready_mode = 0;
  int pat      = 0;
  int start_cyc;

  int hs_cnt, done_cnt, done_cyc, first_valid_cyc, first_hs_cyc, last_hs_cyc;
  int issued, max_out, stall_viol;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       busy_at_done;
  logic [7:0]  rx_q[$];
  logic [10:0] addr_q[$];

  sample_readout #(.AW(11), .DW(8)) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .count(count), .reverse(reverse), .abort(abort), .mem_en(mem_en),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc = cyc + 1;

  always @(posedge clock) if (mem_en) mem_rdata <= mem_addr[7:0];

  // tx_ready: mode 0 always ready, mode 1 three cycles low then one high.
  always @(posedge clock) begin
    #1;
    if (ready_mode == 1) tx_ready = (pat == 3);
    else tx_ready = 1'b1;
    pat = (pat + 1) % 4;
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (mem_en) begin
        addr_q.push_back(mem_addr);
        issued++;
      end
      if (tx_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (prev_stall && tx_data !== prev_data) stall_viol++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) begin
        rx_q.push_back(tx_data);
        hs_cnt++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
      if (issued - hs_cnt > max_out) max_out = issued - hs_cnt;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        busy_at_done = busy;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_mon();
    rx_q.delete(); addr_q.delete();
    hs_cnt = 0; done_cnt = 0; done_cyc = -1; first_valid_cyc = -1;
    first_hs_cyc = -1; last_hs_cyc = -1; issued = 0; max_out = 0;
    stall_viol = 0; prev_stall = 1'b0; prev_data = 8'h00; busy_at_done = 1'b1;
  endtask

  task automatic do_start(input logic [10:0] a, input logic [11:0] n, input logic rev);
    @(posedge clock); #1;
    start = 1'b1; start_addr = a; count = n; reverse = rev;
    @(posedge clock); #1;
    start = 1'b0;
    start_cyc = cyc;
    if (n != 12'd0) begin
      check("busy_after_start", busy, 1);
      check("first_mem_en", mem_en, 1);
      check("first_mem_addr", mem_addr, a);
    end else begin
      check("zero_done", done, 1);
      check("zero_busy", busy, 0);
      check("zero_mem_en", mem_en, 0);
    end
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done_cnt == 0 && n < max_cyc) begin
      @(negedge clock); #1;
      n++;
    end
    check("done_seen", (done_cnt != 0), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_mem_en"}, mem_en, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_tx_data"}, tx_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic run_forward(input string tag);
    clear_mon();
    ready_mode = 0;
    do_start(11'h010, 12'd4, 1'b0);
    wait_done(40);
    check({tag, "_words"}, rx_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("%s_data%0d", tag, i), rx_q[i], 8'h10 + i);
    // start sampled at edge s; first valid cycle begins at edge s+2 (3 cycles after start)
    check({tag, "_valid_latency"}, first_valid_cyc - start_cyc, 2);
    check({tag, "_back_to_back"}, last_hs_cyc - first_hs_cyc, 3);
    check({tag, "_done_timing"}, done_cyc - last_hs_cyc, 1);
    check({tag, "_busy_at_done"}, busy_at_done, 0);
    check({tag, "_done_count"}, done_cnt, 1);
  endtask

  initial begin
    logic [10:0] exp_a[4];
    logic [7:0]  exp_d[4];
    int n, errs;

    reset = 1'b1; start = 1'b0; start_addr = 11'h000; count = 12'd0;
    reverse = 1'b0; abort = 1'b0;
    clear_mon();
    #3;
    check_outputs_zero("rst_early");
    repeat (2) @(posedge clock);
    #1;
    check_outputs_zero("rst_held");
    reset = 1'b0;

    run_forward("fwd");

    // Reverse run across address 0
    clear_mon();
    do_start(11'h001, 12'd4, 1'b1);
    wait_done(40);
    exp_a = '{11'h001, 11'h000, 11'h7FF, 11'h7FE};
    exp_d = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    check("rev_reads", addr_q.size(), 4);
    check("rev_words", rx_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rev_addr%0d", i), addr_q[i], exp_a[i]);
      check($sformatf("rev_data%0d", i), rx_q[i], exp_d[i]);
    end

    // Back-pressure 3 low / 1 high
    clear_mon();
    ready_mode = 1;
    do_start(11'h020, 12'd8, 1'b0);
    wait_done(200);
    ready_mode = 0;
    check("bp_words", rx_q.size(), 8);
    errs = 0;
    for (int i = 0; i < 8; i++) if (rx_q[i] !== 8'h20 + i) errs++;
    check("bp_order", errs, 0);
    check("bp_reads", addr_q.size(), 8);
    check("bp_max_outstanding_le2", (max_out <= 2), 1);
    check("bp_stall_stable", stall_viol, 0);

    // count = 0
    clear_mon();
    do_start(11'h100, 12'd0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("zero_reads", addr_q.size(), 0);
    check("zero_done_count", done_cnt, 1);

    // Full ring from 0x400
    clear_mon();
    do_start(11'h400, 12'd2048, 1'b0);
    wait_done(2200);
    check("full_words", rx_q.size(), 2048);
    errs = 0;
    for (int i = 0; i < 2048; i++) if (rx_q[i] !== 8'((12'h400 + i) & 12'h0FF)) errs++;
    check("full_data", errs, 0);
    check("full_addr_7ff", addr_q[1023], 11'h7FF);
    check("full_addr_wrap", addr_q[1024], 11'h000);

    // Abort after the 5th handshake
    clear_mon();
    do_start(11'h050, 12'd16, 1'b0);
    n = 0;
    while (hs_cnt < 5 && n < 50) begin
      @(negedge clock); #1;
      n++;
    end
    check("abort_reached5", (hs_cnt >= 5), 1);
    @(posedge clock); #1;
    abort = 1'b1;
    @(posedge clock); #1;
    abort = 1'b0;
    check("abort_tx_valid", tx_valid, 0);
    check("abort_mem_en", mem_en, 0);
    check("abort_busy", busy, 0);
    repeat (4) @(posedge clock);
    #1;
    check("abort_no_done", done_cnt, 0);
    clear_mon();
    do_start(11'h060, 12'd6, 1'b0);
    wait_done(40);
    check("post_abort_words", rx_q.size(), 6);
    errs = 0;
    for (int i = 0; i < 6; i++) if (rx_q[i] !== 8'h60 + i) errs++;
    check("post_abort_data", errs, 0);

    // Asynchronous reset between edges
    clear_mon();
    do_start(11'h030, 12'd16, 1'b0);
    repeat (4) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    @(posedge clock); #1;
    reset = 1'b0;
    check("post_rst_busy", busy, 0);
    check("post_rst_mem_en", mem_en, 0);
    run_forward("fwd2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sample_readout.md
# sample_readout

Streams a contiguous window of captured samples out of the sample block RAM to the host-side transmitter. It is the read side of the capture memory: the sampler writes the RAM, and this block reads it back. It issues addressed reads to the single-port RAM, which has one cycle of read latency, and buffers the returned words in a 2-entry FIFO. It presents the words on a valid/ready stream that back-pressures cleanly. It supports ascending or descending address order with modulo wrap, so the trigger-relative window can start anywhere in the ring.

## Interface
- AW, 11, RAM address width; the ring depth is 2^AW.
- DW, 8, sample word width.
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- start_addr  in  AW  address of the first word read.
- count  in  AW+1  number of words to send, 0..2^AW.
- reverse  in  1  0 = address increments, 1 = address decrements; latched at start.
- abort  in  1  cancels the transfer from any state.
- mem_en  out  1  RAM read enable.
- mem_addr  out  AW  RAM address; meaningful only when mem_en is high.
- mem_rdata  in  DW  RAM data, valid the cycle after mem_en.
- tx_data  out  DW  stream data.
- tx_valid  out  1  stream valid.
- tx_ready  in  1  stream ready from the transmitter.
- busy  out  1  high from the cycle after start until the cycle done fires.
- done  out  1  one-cycle pulse after the last word is accepted.

## Operation
- States:
  - IDLE: start and count≠0 → READ; start and count=0 → done pulse, stay in IDLE.
  - READ: reads are issued; after the last read issues → DRAIN.
  - DRAIN: waits until the FIFO is empty and no read is in flight → done, then IDLE.
- Latched at start: start_addr, count, reverse. Remaining-read counter = count; remaining-send counter = count.
- Read issue rule in READ: mem_en = (reads_left≠0) && (occ + inflight − pop < 2).
  - pop = tx_valid && tx_ready.
  - inflight = mem_en of the previous cycle.
  - The FIFO therefore never overflows, and no RAM data is ever dropped.
- Each issued read advances the address by ±1, modulo 2^AW, so 0 wraps to 2^AW−1 in reverse mode and 2^AW−1 wraps to 0 in forward mode.
- Returned mem_rdata is pushed into the FIFO on the edge after the mem_en cycle. The FIFO head drives tx_data and tx_valid.
- tx_data is held stable while tx_valid && !tx_ready.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- start while busy is ignored.
- abort has priority over every other event, including a coincident start or a final handshake:
  - next state is IDLE;
  - the FIFO is flushed and any in-flight return is discarded;
  - tx_valid, mem_en and busy are low on the next cycle;
  - no done pulse is issued.
- Reset forces IDLE. Every output is 0 during and after reset: mem_en, mem_addr, tx_valid, tx_data, busy, done.

## Timing
- Start sampled at edge E0:
  - busy and the first mem_en go high after E0;
  - the first word is in the FIFO at E2;
  - tx_valid goes high after E2, i.e. 3 cycles after start.
- Sustained throughput is 1 word per cycle while tx_ready is held high.
- After tx_ready falls, at most 2 further words land in the FIFO. Reads resume in the same cycle that a pop frees a slot.
- done is high in the cycle after the edge that accepts the last word. busy falls in that same cycle.
- count=0: done is high the cycle after start, and busy never rises.

## Structure
- Shared package `sample_readout_pkg`:
  - the state encoding (IDLE=0, READ=1, DRAIN=2);
  - the default AW and DW.
- One sub-module, `fifo2`: a 2-entry synchronous FIFO with push, pop, head data, occupancy, and an asynchronous reset of its pointers and occupancy.
- Address and credit logic stay in the top level.

## Test plan
- Forward run: start_addr=0x010, count=4, RAM[i]=i&0xFF, tx_ready=1 → tx_data 0x10,0x11,0x12,0x13 on consecutive cycles. tx_valid first rises 3 cycles after start. done is high the cycle after 0x13 is accepted.
- Reverse wrap: start_addr=0x001, count=4, reverse=1 → mem_addr sequence 0x001,0x000,0x7FF,0x7FE; tx_data 0x01,0x00,0xFF,0xFE.
- Back-pressure: count=8, tx_ready toggles on a 3-low/1-high pattern → all 8 words are delivered in order with no loss or duplication. mem_en never makes occ exceed 2. tx_data is stable while stalled.
- Edge counts: count=0 → done one cycle after start, no mem_en. count=2048 from 0x400 → 2048 words, with the address wrapping through 0x7FF to 0x000.
- Abort mid-transfer: count=16, abort is asserted after the 5th handshake → tx_valid, mem_en and busy are 0 next cycle, with no done pulse. A new start after that delivers its full window correctly.
- Async reset mid-transfer: reset is asserted between clock edges → all outputs read 0 immediately. After release, the block is in IDLE and the next start behaves as in the forward-run scenario.
